// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with one registered response slot per requester and a saturating conflict counter.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [OP_WIDTH-1:0]   req0_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [OP_WIDTH-1:0]   req1_op,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,

    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_WIDTH-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,

    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic                  elig0, elig1;
    logic                  grant0, grant1;
    logic                  last_grant_q, last_grant_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic [DATA_WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // A slot being drained this cycle counts as free.
    always_comb begin
        elig0  = req0_valid & (~rsp0_valid_q | rsp0_ready);
        elig1  = req1_valid & (~rsp1_valid_q | rsp1_ready);
        // last_grant_q == 1 means port 1 won most recently, so port 0 wins a tie.
        grant0 = elig0 & (~elig1 | last_grant_q);
        grant1 = elig1 & (~elig0 | ~last_grant_q);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (grant0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (grant1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end

        rsp0_valid_d  = grant0 | (rsp0_valid_q & ~rsp0_ready);
        rsp1_valid_d  = grant1 | (rsp1_valid_q & ~rsp1_ready);
        rsp0_result_d = grant0 ? alu_result : rsp0_result_q;
        rsp1_result_d = grant1 ? alu_result : rsp1_result_q;

        cnt_d = cnt_q;
        if (elig0 && elig1 && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q  <= 1'b1;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            cnt_q         <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            cnt_q         <= cnt_d;
        end
    end

    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp0_result  = rsp0_result_q;
    assign rsp1_result  = rsp1_result_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model; also models the shared ALU.
module tb_alu_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned OW  = 4;
    localparam int unsigned CW  = 8;
    localparam int          MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OW-1:0] req0_op, req1_op;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [DW-1:0] rsp0_result, rsp1_result;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [OW-1:0] alu_op;
    logic [CW-1:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .DATA_WIDTH (DW),
        .OP_WIDTH   (OW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp0_result  (rsp0_result),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp1_result  (rsp1_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .conflict_cnt (conflict_cnt)
    );

    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a & b;
            4'd5:    return ~(a | b);
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return $signed(a) >>> b[4:0];
            4'd11:   return b << 16;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // The shared ALU sitting outside the arbiter.
    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    // Transaction-level model: slot contents, last winner, conflict count.
    logic          m_vld [2];
    logic [DW-1:0] m_res [2];
    int            m_last;
    int            m_cnt;
    int            m_w;
    logic          m_e0, m_e1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called #1 after inputs settle: predict the winner and compare all outputs.
    task automatic settle();
        logic [DW-1:0] ea, eb;
        logic [OW-1:0] eo;
        #1;
        m_e0 = req0_valid && (!m_vld[0] || rsp0_ready);
        m_e1 = req1_valid && (!m_vld[1] || rsp1_ready);
        if (m_e0 && m_e1) m_w = 1 - m_last;
        else if (m_e0)    m_w = 0;
        else if (m_e1)    m_w = 1;
        else              m_w = -1;
        ea = (m_w == 0) ? req0_a  : (m_w == 1) ? req1_a  : '0;
        eb = (m_w == 0) ? req0_b  : (m_w == 1) ? req1_b  : '0;
        eo = (m_w == 0) ? req0_op : (m_w == 1) ? req1_op : '0;
        check("req0_ready", 32'(req0_ready), 32'(m_w == 0));
        check("req1_ready", 32'(req1_ready), 32'(m_w == 1));
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_op", 32'(alu_op), 32'(eo));
        check("rsp0_valid", 32'(rsp0_valid), 32'(m_vld[0]));
        check("rsp1_valid", 32'(rsp1_valid), 32'(m_vld[1]));
        check("rsp0_result", rsp0_result, m_res[0]);
        check("rsp1_result", rsp1_result, m_res[1]);
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_vld[0] = 1'b0; m_vld[1] = 1'b0;
            m_res[0] = '0;   m_res[1] = '0;
            m_cnt = 0; m_last = 1;
        end else begin
            if (m_w == 0)                  begin m_vld[0] = 1'b1;
                                                 m_res[0] = alu_fn(req0_a, req0_b, req0_op); end
            else if (m_vld[0] && rsp0_ready) m_vld[0] = 1'b0;
            if (m_w == 1)                  begin m_vld[1] = 1'b1;
                                                 m_res[1] = alu_fn(req1_a, req1_b, req1_op); end
            else if (m_vld[1] && rsp1_ready) m_vld[1] = 1'b0;
            if (m_e0 && m_e1) m_cnt = (m_cnt == MAX) ? MAX : m_cnt + 1;
            if (m_w >= 0) m_last = m_w;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0; rsp0_ready = 1;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0; rsp1_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        settle();
        tick();
        rst = 0;
    endtask

    initial begin
        m_vld[0] = 0; m_vld[1] = 0; m_res[0] = '0; m_res[1] = '0;
        m_last = 1; m_cnt = 0; m_w = -1; m_e0 = 0; m_e1 = 0;
        idle_inputs();
        rst = 1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        settle();
        check("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("reset_cnt", 32'(conflict_cnt), 32'd0);
        check("idle_alu_op", 32'(alu_op), 32'd0);
        tick();

        // Single add, 1-cycle latency, drained next cycle.
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 0;
        settle();
        check("add_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 0;
        settle();
        check("add_rsp_valid", 32'(rsp0_valid), 32'd1);
        check("add_result", rsp0_result, 32'd8);
        tick();
        settle();
        check("add_drained", 32'(rsp0_valid), 32'd0);
        tick();

        // Conflict from reset: port 0 first.
        do_reset();
        req0_valid = 1; req0_a = 10; req0_b = 4; req0_op = 1;
        req1_valid = 1; req1_a = 32'hFFFF_FFFF; req1_b = 1; req1_op = 2;
        settle();
        check("conf_g0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 0;
        settle();
        check("sub_result", rsp0_result, 32'd6);
        check("conf_g1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 0;
        settle();
        check("slt_result", rsp1_result, 32'd1);
        check("conf_cnt1", 32'(conflict_cnt), 32'd1);
        tick();

        // Backpressure on the response slot blocks a second request.
        do_reset();
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 0; req0_b = 32'h1234; req0_op = 11;
        settle();
        tick();
        req0_a = 1; req0_b = 1; req0_op = 0;
        settle();
        check("bp_blocked", 32'(req0_ready), 32'd0);
        check("bp_lui", rsp0_result, 32'h1234_0000);
        tick();
        settle();
        check("bp_hold", rsp0_result, 32'h1234_0000);
        tick();
        rsp0_ready = 1;
        settle();
        check("bp_accept", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 0;
        settle();
        check("bp_result", rsp0_result, 32'd2);
        tick();

        // Alternation under continuous conflict, then saturation.
        do_reset();
        req0_valid = 1; req0_a = 2; req0_b = 3; req0_op = 6;
        req1_valid = 1; req1_a = 9; req1_b = 5; req1_op = 7;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("alt_grant1", 32'(req1_ready), 32'(i % 2));
            tick();
        end
        settle();
        check("alt_cnt6", 32'(conflict_cnt), 32'd6);
        for (int i = 0; i < MAX + 4; i++) begin
            tick();
            settle();
        end
        check("sat_cnt", 32'(conflict_cnt), 32'(MAX));
        tick();
        req0_valid = 0; req1_valid = 0;
        settle();
        tick();

        // Undefined opcode passes through; idle bus is zero.
        req1_valid = 1; req1_a = 7; req1_b = 9; req1_op = 12;
        settle();
        tick();
        req1_valid = 0;
        settle();
        check("op12_result", rsp1_result, 32'hFFFF_FFFF);
        check("idle_alu_a", alu_a, 32'd0);
        check("idle_alu_b", alu_b, 32'd0);
        tick();

        // Reset discards an unconsumed result and restores port-0 priority.
        do_reset();
        rsp0_ready = 0;
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 0;
        settle();
        tick();
        req0_valid = 0;
        settle();
        check("pre_rst_result", rsp0_result, 32'd8);
        rst = 1;
        tick();
        rst = 0;
        rsp0_ready = 1;
        req0_valid = 1; req1_valid = 1;
        settle();
        check("rst_valid", 32'(rsp0_valid), 32'd0);
        check("rst_result", rsp0_result, 32'd0);
        check("rst_cnt", 32'(conflict_cnt), 32'd0);
        check("rst_prio", 32'(req0_ready), 32'd1);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!(req0_valid && m_w != 0)) begin
                req0_valid = ($urandom % 10) < 6;
                req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom % 16);
            end
            if (!(req1_valid && m_w != 1)) begin
                req1_valid = ($urandom % 10) < 6;
                req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom % 16);
            end
            rsp0_ready = ($urandom % 10) < 7;
            rsp1_ready = ($urandom % 10) < 7;
            rst = ($urandom % 200) == 0;
            settle();
            tick();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters: the EX-stage datapath (port 0) and an auxiliary address/compare unit (port 1).
- Round-robin arbitration, valid/ready handshakes on both request and response sides, one registered response slot per requester.
- Drives the ALU's A/B/ALUop inputs and captures its Result. One ALU operation per cycle; fixed 1-cycle accept-to-response latency.

Parameters:
DATA_WIDTH, 32, operand/result width (matches ALU)
OP_WIDTH, 4, ALU opcode width
CNT_WIDTH, 16, width of saturating conflict counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  DATA_WIDTH  operand A
req0_b  in  DATA_WIDTH  operand B
req0_op  in  OP_WIDTH  ALU opcode (0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui)
rsp0_valid  out  1  response slot 0 holds a result
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  DATA_WIDTH  registered result for requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as port 0, for requester 1
rsp1_valid, rsp1_ready, rsp1_result  same as port 0, for requester 1
alu_a  out  DATA_WIDTH  to ALU A
alu_b  out  DATA_WIDTH  to ALU B
alu_op  out  OP_WIDTH  to ALU ALUop
alu_result  in  DATA_WIDTH  from ALU Result (combinational)
conflict_cnt  out  CNT_WIDTH  cycles in which both requesters were eligible

Behaviour:
- Clock `clk`, reset `rst`; one clock domain; reset is synchronous and active-high.
- Reset values: rsp0/1_valid=0, rsp0/1_result=0, conflict_cnt=0, last_grant=1 (port 0 wins first conflict). Reset mid-operation discards any pending response; an accepted-but-unconsumed result is lost.
- Eligibility: eligN = reqN_valid & (~rspN_valid | rspN_ready). A response slot being drained this cycle counts as free, so accept and drain can happen in the same cycle.
- Grant:
  - Only one port eligible: grant it.
  - Both eligible: grant the port not equal to last_grant, then update last_grant to the winner.
  - No eligible port: no grant; last_grant holds.
- reqN_ready = grantN. This is combinational from valid and slot state. Requesters must hold valid, a, b and op stable until ready.
- ALU drive: on grant, alu_a/alu_b/alu_op = the granted port's operands. With no grant, drive 0/0/0 (add of zeros).
- Capture: on the grant edge, rspN_result <= alu_result and rspN_valid <= 1. Result is visible on the cycle after accept: latency exactly 1.
- Drain: rspN_valid & rspN_ready with no new grant to N clears rspN_valid; rspN_result holds its last value. Drain plus new grant: valid stays 1 and result is overwritten.
- rspN_valid stays high with result stable until rspN_ready.
- Opcodes 12–15 pass through unchanged. The ALU returns 32'hFFFFFFFF for these and that value is returned. No error flag.
- conflict_cnt increments by 1 each cycle elig0 & elig1. Saturates at all-ones and never wraps.
- Throughput: one grant per cycle total. Two continuously eligible ports alternate 0,1,0,1.

Test Plan:
- req0 add a=5 b=3 at cycle t, rsp0_ready=1 -> req0_ready=1 at t; rsp0_valid=1, rsp0_result=8 at t+1; rsp0_valid=0 at t+2.
- Both valid at t, req0 sub 10,4 and req1 slt 32'hFFFFFFFF,1 -> grant 0 at t, rsp0_result=6 at t+1; grant 1 at t+1, rsp1_result=1 at t+2; conflict_cnt=1.
- rsp0_ready=0, req0 lui b=32'h1234 then second req0 add 1,1 -> second req0_ready=0 while rsp0_valid holds 32'h12340000. In the cycle rsp0_ready=1, the second op is accepted; rsp0_result=2 next cycle.
- Both valid for 6 cycles, all slots draining -> grants 0,1,0,1,0,1; conflict_cnt=6. Force counter to 16'hFFFE, 3 more conflict cycles -> 16'hFFFF.
- req1 op=12 a=7 b=9 -> rsp1_result=32'hFFFFFFFF; idle cycles show alu_op=0, alu_a=alu_b=0.
- rsp0_valid=1 with result 8, assert rst one cycle -> next cycle rsp0_valid=0, rsp0_result=0, conflict_cnt=0; next conflict grants port 0.
